// File: rtl/dshot_rx_pkg.sv
// Shared DShot receiver definitions: bit-period table, FSM encoding and frame CRC.
package dshot_rx_pkg;

  localparam int unsigned CLK_HZ     = 12_000_000;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BIT_CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_RECOVER
  } state_t;

  // Rate-to-bit-period table, shared with the baud generator; unknown rates use the slowest period.
  function automatic int unsigned bit_cyc_for(input int unsigned rate);
    case (rate)
      600000:  return 20;
      300000:  return 40;
      default: return 80;
    endcase
  endfunction

  function automatic logic [3:0] dshot_crc(input logic [11:0] value);
    return 4'(value ^ (value >> 4) ^ (value >> 8));
  endfunction

endpackage

// File: rtl/dshot_crc4.sv
// Combinational 4-bit DShot checksum over the 12-bit throttle/telemetry field.
module dshot_crc4
  import dshot_rx_pkg::*;
(
  input  logic [11:0] value,
  output logic [3:0]  crc_c
);

  assign crc_c = dshot_crc(value);

endmodule

// File: rtl/dshot_rx.sv
// DShot frame receiver: synchronizes the line, times each high pulse and checks the frame CRC.
module dshot_rx
  import dshot_rx_pkg::*;
#(
  parameter int unsigned DSHOT_RATE = 150000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        dshot_in,
  output logic [10:0] throttle,
  output logic        telemetry,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err
);

  localparam int unsigned BIT_CYC = bit_cyc_for(DSHOT_RATE);
  localparam int unsigned CNT_W   = $clog2(2 * BIT_CYC + 1);
  localparam int unsigned LEN_W   = CNT_W + 1;

  typedef logic [LEN_W-1:0] len_t;

  localparam len_t LEN_BIT    = len_t'(BIT_CYC);
  localparam len_t LEN_HALF   = len_t'(BIT_CYC / 2);
  localparam len_t LEN_GLITCH = len_t'(BIT_CYC / 8);
  localparam len_t LEN_GAP    = len_t'(2 * BIT_CYC);

  state_t                 state, state_n;
  logic [2:0]             sync;
  logic [CNT_W-1:0]       cnt, cnt_n, cnt_inc;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-2:0]  shreg, shreg_n;
  logic [FRAME_BITS-1:0]  frame_word;
  logic [3:0]             crc_calc_c;
  logic                   line, rise, fall, bit_val, crc_ok;
  logic                   valid_n, crc_err_n, frame_err_n;
  len_t                   len;

  // sync[1:0] is the two-flop synchronizer; sync[2] holds the previous synchronized sample.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], dshot_in};
  end

  assign line = sync[1];
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  // len counts line samples of the current level seen before this cycle, edge cycle included.
  assign len        = len_t'(cnt) + len_t'(1);
  assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign bit_val    = (len >= LEN_HALF);
  assign frame_word = {shreg, bit_val};
  assign crc_ok     = (crc_calc_c == frame_word[3:0]);

  dshot_crc4 u_crc (
    .value (frame_word[15:4]),
    .crc_c (crc_calc_c)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt_inc;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    valid_n     = 1'b0;
    crc_err_n   = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (rise) begin
          bit_cnt_n = '0;
          state_n   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          cnt_n = '0;
          if (len >= LEN_BIT || len < LEN_GLITCH) begin
            frame_err_n = 1'b1;
            state_n     = ST_RECOVER;
          end else begin
            shreg_n   = {shreg[FRAME_BITS-3:0], bit_val};
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            state_n   = ST_LOW;
            if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
              valid_n   = crc_ok;
              crc_err_n = ~crc_ok;
            end
          end
        end else if (len >= LEN_BIT) begin
          cnt_n       = '0;
          frame_err_n = 1'b1;
          state_n     = ST_RECOVER;
        end
      end
      ST_LOW: begin
        if (rise) begin
          cnt_n   = '0;
          state_n = ST_HIGH;
          if (bit_cnt == BIT_CNT_W'(FRAME_BITS)) bit_cnt_n = '0;
        end else if (len >= LEN_GAP) begin
          cnt_n       = '0;
          state_n     = ST_IDLE;
          frame_err_n = (bit_cnt != BIT_CNT_W'(FRAME_BITS));
        end
      end
      ST_RECOVER: begin
        if (line) begin
          cnt_n = '0;
        end else if (len >= LEN_GAP) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      throttle    <= '0;
      telemetry   <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      frame_valid <= valid_n;
      crc_err     <= crc_err_n;
      frame_err   <= frame_err_n;
      if (valid_n) begin
        throttle  <= frame_word[15:5];
        telemetry <= frame_word[4];
      end
    end
  end

endmodule

// File: tb/tb_dshot_rx.sv
// Scoreboard bench for dshot_rx at all three bit rates.
module tb_dshot_rx;

  localparam int K_VALID = 0;
  localparam int K_CRC   = 1;
  localparam int K_FERR  = 2;

  typedef struct packed {
    logic [1:0]  dut;
    logic [1:0]  kind;
    logic [10:0] thr;
    logic        tel;
    logic        from_rise;
    logic [8:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        din;
  logic [2:0][10:0]  thr;
  logic [2:0]        tel, fv, ce, fe;

  // index 0: 150k, 1: 300k, 2: 600k
  int h1[3] = '{60, 30, 15};
  int l1[3] = '{20, 10, 5};
  int h0[3] = '{30, 15, 7};
  int l0[3] = '{50, 25, 13};

  exp_t        exp_q[$];
  exp_t        e;
  logic [10:0] m_thr[3];
  logic        m_tel[3];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;

  dshot_rx #(.DSHOT_RATE(150000)) u_150 (
    .clk_in(clk), .rst_n(rst_n), .dshot_in(din[0]), .throttle(thr[0]), .telemetry(tel[0]),
    .frame_valid(fv[0]), .crc_err(ce[0]), .frame_err(fe[0]));
  dshot_rx #(.DSHOT_RATE(300000)) u_300 (
    .clk_in(clk), .rst_n(rst_n), .dshot_in(din[1]), .throttle(thr[1]), .telemetry(tel[1]),
    .frame_valid(fv[1]), .crc_err(ce[1]), .frame_err(fe[1]));
  dshot_rx #(.DSHOT_RATE(600000)) u_600 (
    .clk_in(clk), .rst_n(rst_n), .dshot_in(din[2]), .throttle(thr[2]), .telemetry(tel[2]),
    .frame_valid(fv[2]), .crc_err(ce[2]), .frame_err(fe[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse on any DUT must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fv[i] | ce[i] | fe[i]) begin
        chk("one_hot", 32'(fv[i]) + 32'(ce[i]) + 32'(fe[i]), 1);
        if (exp_q.size() == 0) begin
          chk("spurious", {i[7:0], 5'd0, fv[i], ce[i], fe[i]}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dut", i, 32'(e.dut));
          chk("kind", fv[i] ? K_VALID : (ce[i] ? K_CRC : K_FERR), 32'(e.kind));
          chk("thr", 32'(thr[i]), 32'(e.thr));
          chk("tel", 32'(tel[i]), 32'(e.tel));
          if (e.lat != 0)
            chk("lat", cyc - (e.from_rise ? rise_cyc : fall_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int d, input int h, input int l);
    din[d] = 1'b1;
    rise_cyc = cyc;
    repeat (h) @(negedge clk);
    din[d] = 1'b0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bits(input int d, input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      if (w[i]) pulse(d, h1[d], l1[d]);
      else      pulse(d, h0[d], l0[d]);
    end
  endtask

  // Reference CRC from the frame definition; a good frame updates the model before pushing.
  task automatic exp_frame(input int d, input logic [15:0] w);
    logic [11:0] v;
    logic [3:0]  c;
    exp_t        x;
    v = w[15:4];
    c = 4'((v ^ (v >> 4) ^ (v >> 8)) & 12'hF);
    if (c == w[3:0]) begin
      m_thr[d] = v[11:1];
      m_tel[d] = v[0];
    end
    x.dut = 2'(d);
    x.kind = (c == w[3:0]) ? 2'(K_VALID) : 2'(K_CRC);
    x.thr = m_thr[d];
    x.tel = m_tel[d];
    x.from_rise = 1'b0;
    x.lat = 9'd3;
    exp_q.push_back(x);
  endtask

  task automatic exp_ferr(input int d, input logic from_rise, input int lat);
    exp_t x;
    x.dut = 2'(d);
    x.kind = 2'(K_FERR);
    x.thr = m_thr[d];
    x.tel = m_tel[d];
    x.from_rise = from_rise;
    x.lat = 9'(lat);
    exp_q.push_back(x);
  endtask

  task automatic frame(input int d, input logic [15:0] w);
    exp_frame(d, w);
    send_bits(d, w, 16);
  endtask

  task automatic drained(input string tag);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_thr"}, 32'(thr[i]), 0);
      chk({tag, "_tel"}, 32'(tel[i]), 0);
      chk({tag, "_pulse"}, {29'd0, fv[i], ce[i], fe[i]}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    for (int i = 0; i < 3; i++) begin
      m_thr[i] = '0;
      m_tel[i] = 1'b0;
    end
    idle(5);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(20);

    // Back-to-back good, bad-CRC and good frames.
    frame(0, 16'h82C6);
    frame(0, 16'h82C7);
    frame(0, 16'h0617);
    idle(200);
    chk("thr_0617", 32'(thr[0]), 48);
    chk("tel_0617", 32'(tel[0]), 1);
    drained("pend_basic");

    frame(0, 16'h82C6);
    idle(200);
    chk("thr_82C6", 32'(thr[0]), 1046);
    chk("tel_82C6", 32'(tel[0]), 0);
    drained("pend_82c6");

    // 8 bits then silence: 160 low samples, plus two sync flops and the output register.
    exp_ferr(0, 1'b0, 2 * 80 + 3);
    send_bits(0, 16'h82C6, 8);
    idle(250);
    frame(0, 16'h0617);
    idle(200);
    drained("pend_lowto");

    // Short glitch mid-frame, then recovery and a clean frame.
    exp_ferr(0, 1'b0, 3);
    send_bits(0, 16'h82C6, 4);
    pulse(0, 5, 170);
    frame(0, 16'h82C6);
    idle(200);
    drained("pend_glitch");

    // Over-long high pulse trips at 80 high samples while the line is still high.
    exp_ferr(0, 1'b1, 80 + 3);
    pulse(0, 90, 170);
    frame(0, 16'h0617);
    idle(200);
    chk("thr_after_long", 32'(thr[0]), 48);
    drained("pend_long");

    // Reset in the high phase of bit 10 discards the partial frame silently.
    send_bits(0, 16'h82C6, 9);
    din[0] = 1'b1;
    idle(20);
    rst_n = 1'b0;
    idle(2);
    chk_reset_outputs("midrst");
    din[0] = 1'b0;
    idle(5);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_thr[i] = '0;
      m_tel[i] = 1'b0;
    end
    idle(250);
    drained("pend_midrst");
    frame(0, 16'h0617);
    idle(200);
    chk("thr_after_rst", 32'(thr[0]), 48);
    drained("pend_after_rst");

    // Faster rates.
    for (int d = 1; d < 3; d++) begin
      frame(d, 16'h82C6);
      frame(d, 16'h82C7);
      idle(200);
      chk("thr_rate", 32'(thr[d]), 1046);
      chk("tel_rate", 32'(tel[d]), 0);
      drained("pend_rate");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
